// File: rtl/product_bcd_converter_if.sv
`default_nettype none
// ============================================================================
// Module     : product_bcd_converter_if
// Description: Handshake/data bundle between a requester (multiplier product
//              path) and the product_bcd_converter.
//                master : drives start, binIn (and hexMode when enabled),
//                         observes ready/busy/done/bcdOut/overflow
//                slave  : the converter itself
//              Optional macro BCD_CONV_HEX_MODE_EN adds the hexMode request bit.
// Revision   : 1.0  initial release
// ============================================================================
interface product_bcd_converter_if #(
  parameter int BIN_WIDTH = 10,
  parameter int DIGITS    = 4
);

  // request side
  logic                   start;
  logic [BIN_WIDTH-1:0]   binIn;
`ifdef BCD_CONV_HEX_MODE_EN
  logic                   hexMode;
`endif

  // response side
  logic                   ready;
  logic                   busy;
  logic                   done;
  logic [4*DIGITS-1:0]    bcdOut;
  logic                   overflow;

`ifdef BCD_CONV_HEX_MODE_EN
  modport master (
    output start, binIn, hexMode,
    input  ready, busy, done, bcdOut, overflow
  );

  modport slave (
    input  start, binIn, hexMode,
    output ready, busy, done, bcdOut, overflow
  );
`else
  modport master (
    output start, binIn,
    input  ready, busy, done, bcdOut, overflow
  );

  modport slave (
    input  start, binIn,
    output ready, busy, done, bcdOut, overflow
  );
`endif

endinterface

`default_nettype wire

// File: rtl/product_bcd_converter.sv
`default_nettype none
// ============================================================================
// Module     : product_bcd_converter
// Description: Sequential double-dabble binary-to-BCD converter for the
//              multiplier product feeding the seven-segment display.
//              A start strobe (accepted while ready=1) captures binIn; the value
//              is shifted through a BCD scratch register over BIN_WIDTH cycles,
//              then bcdOut/overflow are updated together with a one-cycle done.
//              If DIGITS is too small, bcdOut holds the value modulo 10^DIGITS
//              and overflow is set.
// Ports      : clock   - system clock, rising edge
//              reset   - asynchronous, active-high, clears all state
//              bus     - product_bcd_converter_if.slave
//                        start/binIn[/hexMode] in, ready/busy/done/bcdOut/
//                        overflow out (all outputs registered)
// Options    : BCD_CONV_HEX_MODE_EN - adds bus.hexMode; when set with start
//              the value is passed through as hex nibbles (IDLE->DONE directly),
//              overflow flags any truncated binIn bit.
// Revision   : 1.0  initial release
// ============================================================================
module product_bcd_converter #(
  parameter int BIN_WIDTH = 10,
  parameter int DIGITS    = 4
) (
  input  wire logic               clock,
  input  wire logic               reset,
  product_bcd_converter_if.slave  bus
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = (BIN_WIDTH > 1) ? $clog2(BIN_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(BIN_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t                 state_q,   state_d;
  logic [BIN_WIDTH-1:0]   shift_q,   shift_d;     // remaining binary bits, MSB first
  logic [BCD_W-1:0]       scratch_q, scratch_d;   // BCD accumulator
  logic [CNT_W-1:0]       count_q,   count_d;     // shift iteration
  logic                   flag_q,    flag_d;      // sticky overflow during conversion
  logic [BCD_W-1:0]       bcd_q,     bcd_d;
  logic                   overflow_q, overflow_d;
  logic                   done_q,    done_d;
  logic                   ready_q,   ready_d;
  logic                   busy_q,    busy_d;

  // --------------------------------------------------------------------------
  // Double-dabble correction: any digit >= 5 gets +3 before the shift, so the
  // following doubling carries correctly into the next digit. Results stay
  // within 4 bits (5..9 -> 8..12).
  // --------------------------------------------------------------------------
  logic [BCD_W-1:0] adjusted;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit_adjust
    assign adjusted[4*i +: 4] = (scratch_q[4*i +: 4] >= 4'd5)
                              ? scratch_q[4*i +: 4] + 4'd3
                              : scratch_q[4*i +: 4];
  end

`ifdef BCD_CONV_HEX_MODE_EN
  // --------------------------------------------------------------------------
  // Hex pass-through: binIn zero-extended or truncated to the BCD field width;
  // any discarded bit set is reported as overflow.
  // --------------------------------------------------------------------------
  logic [BCD_W-1:0] hex_value;
  logic             hex_trunc;

  if (BIN_WIDTH > BCD_W) begin : g_hex_trunc
    assign hex_value = bus.binIn[BCD_W-1:0];
    assign hex_trunc = |bus.binIn[BIN_WIDTH-1:BCD_W];
  end else if (BIN_WIDTH == BCD_W) begin : g_hex_exact
    assign hex_value = bus.binIn;
    assign hex_trunc = 1'b0;
  end else begin : g_hex_extend
    assign hex_value = {{(BCD_W - BIN_WIDTH){1'b0}}, bus.binIn};
    assign hex_trunc = 1'b0;
  end
`endif

  // --------------------------------------------------------------------------
  // Next-state / datapath
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    scratch_d  = scratch_q;
    count_d    = count_q;
    flag_d     = flag_q;
    bcd_d      = bcd_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          shift_d   = bus.binIn;
          scratch_d = '0;
          count_d   = '0;
          flag_d    = 1'b0;
          state_d   = SHIFT;
`ifdef BCD_CONV_HEX_MODE_EN
          if (bus.hexMode) begin
            scratch_d = hex_value;
            flag_d    = hex_trunc;
            state_d   = DONE;
          end
`endif
        end
      end

      SHIFT: begin
        // Next binary MSB enters digit 0; the top digit's MSB leaves the
        // field and represents a lost multiple of 10^DIGITS.
        {scratch_d, shift_d} = {adjusted[BCD_W-2:0], shift_q, 1'b0};
        flag_d  = flag_q | adjusted[BCD_W-1];
        count_d = count_q + CNT_W'(1);
        if (count_q == LAST_COUNT) begin
          state_d = DONE;
        end
      end

      DONE: begin
        bcd_d      = scratch_q;
        overflow_d = flag_q;
        done_d     = 1'b1;
        state_d    = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Status flags registered from the next state so they track state_q
    // exactly while still coming straight from flops.
    ready_d = (state_d == IDLE);
    busy_d  = ~ready_d;
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      scratch_q  <= '0;
      count_q    <= '0;
      flag_q     <= 1'b0;
      bcd_q      <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      scratch_q  <= scratch_d;
      count_q    <= count_d;
      flag_q     <= flag_d;
      bcd_q      <= bcd_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.ready    = ready_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.bcdOut   = bcd_q;
  assign bus.overflow = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_product_bcd_converter.sv
`default_nettype none
// ============================================================================
// Module     : tb_product_bcd_converter
// Description: Directed self-checking bench for product_bcd_converter.
//              dut_a: BIN_WIDTH=10, DIGITS=4.  dut_b: BIN_WIDTH=10, DIGITS=2
//              (overflow cases). Hex-mode scenarios are built only when
//              BCD_CONV_HEX_MODE_EN is defined.
//              Edge counting: n=1 is the first rising edge after the edge that
//              accepted start; outputs are sampled 1 ns after each edge.
// Revision   : 1.0  initial release
// ============================================================================
module tb_product_bcd_converter;

  logic clock;
  logic reset;

  int n_vec;
  int n_fail;

  product_bcd_converter_if #(.BIN_WIDTH(10), .DIGITS(4)) bus_a ();
  product_bcd_converter_if #(.BIN_WIDTH(10), .DIGITS(2)) bus_b ();

  product_bcd_converter #(.BIN_WIDTH(10), .DIGITS(4)) dut_a (
    .clock (clock),
    .reset (reset),
    .bus   (bus_a)
  );

  product_bcd_converter #(.BIN_WIDTH(10), .DIGITS(2)) dut_b (
    .clock (clock),
    .reset (reset),
    .bus   (bus_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Pulse start for one accepting edge; returns 1 ns after that edge.
  task automatic issue(input bit sel, input logic [9:0] bin);
    if (sel) begin
      bus_b.binIn = bin;
      bus_b.start = 1'b1;
    end else begin
      bus_a.binIn = bin;
      bus_a.start = 1'b1;
    end
    @(posedge clock);
    #1;
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
  endtask

  // Observe up to max_edges edges; report first done position and its data.
  task automatic wait_done(input bit sel, input int max_edges,
                           output int lat, output int pulses,
                           output logic [15:0] bcd, output logic ovf);
    lat    = 0;
    pulses = 0;
    bcd    = 'x;
    ovf    = 1'bx;
    for (int n = 1; n <= max_edges; n++) begin
      @(posedge clock);
      #1;
      if ((sel ? bus_b.done : bus_a.done) === 1'b1) begin
        pulses++;
        if (lat == 0) begin
          lat = n;
          bcd = sel ? {8'h00, bus_b.bcdOut} : bus_a.bcdOut;
          ovf = sel ? bus_b.overflow : bus_a.overflow;
        end
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    #3;
    reset = 1'b1;   // mid-cycle, before any clock edge
    #1;
    n_vec++; if (bus_a.ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", bus_a.ready); end
    n_vec++; if (bus_a.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus_a.busy); end
    n_vec++; if (bus_a.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus_a.done); end
    n_vec++; if (bus_a.bcdOut !== 16'h0000) begin n_fail++; $display("FAIL reset_bcd: got %h want 0000", bus_a.bcdOut); end
    n_vec++; if (bus_a.overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", bus_a.overflow); end
    n_vec++; if (bus_b.bcdOut !== 8'h00) begin n_fail++; $display("FAIL reset_bcd_b: got %h want 00", bus_b.bcdOut); end
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_single;
    int lat, pulses;
    logic [15:0] bcd;
    logic ovf;
    n_vec++; if (bus_a.ready !== 1'b1) begin n_fail++; $display("FAIL single_ready_pre: got %b want 1", bus_a.ready); end
    issue(1'b0, 10'd961);
    n_vec++; if (bus_a.busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b want 1", bus_a.busy); end
    n_vec++; if (bus_a.ready !== 1'b0) begin n_fail++; $display("FAIL single_ready: got %b want 0", bus_a.ready); end
    wait_done(1'b0, 20, lat, pulses, bcd, ovf);
    n_vec++; if (lat !== 11) begin n_fail++; $display("FAIL single_latency: got %0d want 11", lat); end
    n_vec++; if (pulses !== 1) begin n_fail++; $display("FAIL single_pulses: got %0d want 1", pulses); end
    n_vec++; if (bcd !== 16'h0961) begin n_fail++; $display("FAIL single_bcd: got %h want 0961", bcd); end
    n_vec++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL single_ovf: got %b want 0", ovf); end
  endtask

  task automatic test_back_to_back;
    int lat1, lat2, pulses;
    logic [15:0] bcd1, bcd2;
    lat1 = 0; lat2 = 0; pulses = 0; bcd1 = 'x; bcd2 = 'x;
    bus_a.binIn = 10'd1023;
    bus_a.start = 1'b1;
    @(posedge clock);
    #1;
    bus_a.binIn = 10'd0;          // start stays high
    for (int n = 1; n <= 30; n++) begin
      @(posedge clock);
      #1;
      if (n == 5) begin
        n_vec++; if (bus_a.bcdOut !== 16'h0961) begin n_fail++; $display("FAIL b2b_hold: got %h want 0961", bus_a.bcdOut); end
      end
      if (n == 11) begin
        n_vec++; if (bus_a.ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_11: got %b want 1", bus_a.ready); end
      end
      if (n == 12) begin
        n_vec++; if (bus_a.ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_12: got %b want 0", bus_a.ready); end
        bus_a.start = 1'b0;
      end
      if (bus_a.done === 1'b1) begin
        pulses++;
        if (lat1 == 0) begin lat1 = n; bcd1 = bus_a.bcdOut; end
        else if (lat2 == 0) begin lat2 = n; bcd2 = bus_a.bcdOut; end
      end
    end
    bus_a.start = 1'b0;
    n_vec++; if (lat1 !== 11) begin n_fail++; $display("FAIL b2b_lat1: got %0d want 11", lat1); end
    n_vec++; if (bcd1 !== 16'h1023) begin n_fail++; $display("FAIL b2b_bcd1: got %h want 1023", bcd1); end
    n_vec++; if (lat2 !== 23) begin n_fail++; $display("FAIL b2b_lat2: got %0d want 23", lat2); end
    n_vec++; if (bcd2 !== 16'h0000) begin n_fail++; $display("FAIL b2b_bcd2: got %h want 0000", bcd2); end
    n_vec++; if (pulses !== 2) begin n_fail++; $display("FAIL b2b_pulses: got %0d want 2", pulses); end
  endtask

  task automatic test_ignored_start;
    int lat, pulses;
    logic [15:0] bcd;
    lat = 0; pulses = 0; bcd = 'x;
    issue(1'b0, 10'd500);
    for (int n = 1; n <= 30; n++) begin
      @(posedge clock);
      #1;
      if (n == 2) begin
        bus_a.binIn = 10'd7;
        bus_a.start = 1'b1;     // sampled at edge 3, while converting
      end
      if (n == 3) bus_a.start = 1'b0;
      if (bus_a.done === 1'b1) begin
        pulses++;
        if (lat == 0) begin lat = n; bcd = bus_a.bcdOut; end
      end
    end
    n_vec++; if (lat !== 11) begin n_fail++; $display("FAIL ignore_latency: got %0d want 11", lat); end
    n_vec++; if (pulses !== 1) begin n_fail++; $display("FAIL ignore_pulses: got %0d want 1", pulses); end
    n_vec++; if (bcd !== 16'h0500) begin n_fail++; $display("FAIL ignore_bcd: got %h want 0500", bcd); end
  endtask

  task automatic test_reset_abort;
    int lat, pulses;
    logic [15:0] bcd;
    logic ovf;
    issue(1'b0, 10'd999);
    for (int n = 1; n <= 4; n++) begin
      @(posedge clock);
      #1;
    end
    #2;
    reset = 1'b1;               // between edge 4 and edge 5
    #1;
    n_vec++; if (bus_a.ready !== 1'b1) begin n_fail++; $display("FAIL abort_ready: got %b want 1", bus_a.ready); end
    n_vec++; if (bus_a.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", bus_a.busy); end
    n_vec++; if (bus_a.bcdOut !== 16'h0000) begin n_fail++; $display("FAIL abort_bcd: got %h want 0000", bus_a.bcdOut); end
    @(posedge clock);
    #1;
    reset = 1'b0;
    wait_done(1'b0, 20, lat, pulses, bcd, ovf);
    n_vec++; if (pulses !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d pulses want 0", pulses); end
    n_vec++; if (bus_a.bcdOut !== 16'h0000) begin n_fail++; $display("FAIL abort_bcd_after: got %h want 0000", bus_a.bcdOut); end
    issue(1'b0, 10'd42);
    wait_done(1'b0, 20, lat, pulses, bcd, ovf);
    n_vec++; if (lat !== 11) begin n_fail++; $display("FAIL abort_next_latency: got %0d want 11", lat); end
    n_vec++; if (bcd !== 16'h0042) begin n_fail++; $display("FAIL abort_next_bcd: got %h want 0042", bcd); end
  endtask

  task automatic test_overflow;
    int lat, pulses;
    logic [15:0] bcd;
    logic ovf;
    issue(1'b1, 10'd150);
    wait_done(1'b1, 20, lat, pulses, bcd, ovf);
    n_vec++; if (lat !== 11) begin n_fail++; $display("FAIL ovf150_latency: got %0d want 11", lat); end
    n_vec++; if (bcd !== 16'h0050) begin n_fail++; $display("FAIL ovf150_bcd: got %h want 0050", bcd); end
    n_vec++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf150_flag: got %b want 1", ovf); end
    issue(1'b1, 10'd99);
    wait_done(1'b1, 20, lat, pulses, bcd, ovf);
    n_vec++; if (bcd !== 16'h0099) begin n_fail++; $display("FAIL ovf99_bcd: got %h want 0099", bcd); end
    n_vec++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf99_flag: got %b want 0", ovf); end
    issue(1'b1, 10'd100);
    wait_done(1'b1, 20, lat, pulses, bcd, ovf);
    n_vec++; if (bcd !== 16'h0000) begin n_fail++; $display("FAIL ovf100_bcd: got %h want 0000", bcd); end
    n_vec++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf100_flag: got %b want 1", ovf); end
  endtask

`ifdef BCD_CONV_HEX_MODE_EN
  task automatic test_hex_mode;
    int lat, pulses;
    logic [15:0] bcd;
    logic ovf;
    bus_a.binIn   = 10'h3C1;
    bus_a.hexMode = 1'b1;
    bus_a.start   = 1'b1;
    @(posedge clock);
    #1;
    bus_a.start   = 1'b0;
    bus_a.hexMode = 1'b0;
    wait_done(1'b0, 10, lat, pulses, bcd, ovf);
    n_vec++; if (lat !== 1) begin n_fail++; $display("FAIL hex_latency: got %0d want 1", lat); end
    n_vec++; if (pulses !== 1) begin n_fail++; $display("FAIL hex_pulses: got %0d want 1", pulses); end
    n_vec++; if (bcd !== 16'h03C1) begin n_fail++; $display("FAIL hex_bcd: got %h want 03c1", bcd); end
    n_vec++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL hex_ovf: got %b want 0", ovf); end
    bus_b.binIn   = 10'h3C1;
    bus_b.hexMode = 1'b1;
    bus_b.start   = 1'b1;
    @(posedge clock);
    #1;
    bus_b.start   = 1'b0;
    bus_b.hexMode = 1'b0;
    wait_done(1'b1, 10, lat, pulses, bcd, ovf);
    n_vec++; if (bcd !== 16'h00C1) begin n_fail++; $display("FAIL hex_trunc_bcd: got %h want 00c1", bcd); end
    n_vec++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL hex_trunc_ovf: got %b want 1", ovf); end
  endtask
`endif

  initial begin
    n_vec  = 0;
    n_fail = 0;
    bus_a.start = 1'b0;
    bus_a.binIn = '0;
    bus_b.start = 1'b0;
    bus_b.binIn = '0;
`ifdef BCD_CONV_HEX_MODE_EN
    bus_a.hexMode = 1'b0;
    bus_b.hexMode = 1'b0;
`endif
    test_reset();
    test_single();
    test_back_to_back();
    test_ignored_start();
    test_reset_abort();
    test_overflow();
`ifdef BCD_CONV_HEX_MODE_EN
    test_hex_mode();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
